// File: rtl/input_pkg.sv
// Shared definitions for the player input block: joystick bit layout,
// SOCD mode encodings, the PS/2 keymap for keyboard players 0 and 1,
// and helpers that translate between joystick bit positions and keymap slots.
package input_pkg;

  // Per-player joystick vector layout: directions, then buttons, then start/coin/pause.
  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_BTN   = 4;

  // Keymap slot layout is the joystick layout with the button field at its widest (6).
  localparam int unsigned KB_MAX_PLAYERS = 2;
  localparam int unsigned NUM_SLOTS      = 13;
  localparam int unsigned SLOT_START     = 10;
  localparam int unsigned SLOT_COIN      = 11;
  localparam int unsigned SLOT_PAUSE     = 12;

  typedef enum logic [1:0] {
    SOCD_PASS    = 2'd0,
    SOCD_NEUTRAL = 2'd1,
    SOCD_LAST    = 2'd2,
    SOCD_RSVD    = 2'd3
  } socd_mode_e;

  // Which direction of an axis was asserted most recently.
  typedef enum logic [1:0] {
    AX_NONE = 2'd0,
    AX_NEG  = 2'd1,
    AX_POS  = 2'd2
  } axis_last_e;

  // {extended, scan code}; service keys are '9' and '0'.
  localparam logic [8:0] SVC_KEY0 = 9'h046;
  localparam logic [8:0] SVC_KEY1 = 9'h045;

  // Slots: right, left, down, up, btn0..btn5, start, coin, pause.
  localparam logic [8:0] KEYMAP [KB_MAX_PLAYERS][NUM_SLOTS] = '{
    // Player 0: arrow keys, LCtrl LAlt Space LShift Z X, '1', '5', 'P'
    '{9'h174, 9'h16B, 9'h172, 9'h175,
      9'h014, 9'h011, 9'h029, 9'h012, 9'h01A, 9'h022,
      9'h016, 9'h02E, 9'h04D},
    // Player 1: D A S W, Q E R F G H, '2', '6', 'O'
    '{9'h023, 9'h01C, 9'h01B, 9'h01D,
      9'h015, 9'h024, 9'h02D, 9'h02B, 9'h034, 9'h033,
      9'h01E, 9'h036, 9'h044}
  };

  function automatic int unsigned joy_w(input int unsigned nb);
    return 7 + nb;
  endfunction

  function automatic int unsigned joy_start(input int unsigned nb);
    return JOY_BTN + nb;
  endfunction

  function automatic int unsigned joy_coin(input int unsigned nb);
    return JOY_BTN + nb + 1;
  endfunction

  function automatic int unsigned joy_pause(input int unsigned nb);
    return JOY_BTN + nb + 2;
  endfunction

  // Keymap slot that feeds joystick bit j for a given button count.
  function automatic int unsigned joy_to_slot(input int unsigned j, input int unsigned nb);
    if (j < JOY_BTN + nb) return j;
    if (j == JOY_BTN + nb) return SLOT_START;
    if (j == JOY_BTN + nb + 1) return SLOT_COIN;
    return SLOT_PAUSE;
  endfunction

endpackage

// File: rtl/player_channel.sv
// One player's output conditioning: SOCD resolution on both axes, coin
// pulse stretching and the pause toggle latch. All outputs are registered.
module player_channel
  import input_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = 3,
  parameter logic [15:0] COIN_CYCLES = 16'd4096
) (
  input  logic                               clk_sys,
  input  logic                               reset,
  input  logic [1:0]                         socd_mode,
  input  logic [joy_w(NUM_BUTTONS)-1:0]      raw,
  output logic [joy_w(NUM_BUTTONS)-1:0]      joy_out
);

  localparam int unsigned JOY_W   = joy_w(NUM_BUTTONS);
  localparam int unsigned P_COIN  = joy_coin(NUM_BUTTONS);
  localparam int unsigned P_PAUSE = joy_pause(NUM_BUTTONS);

  axis_last_e       h_last_q, h_last_d;
  axis_last_e       v_last_q, v_last_d;
  logic [3:0]       dir_prev_q, dir_prev_d;
  logic             coin_prev_q, coin_prev_d;
  logic             pause_prev_q, pause_prev_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [JOY_W-1:0] out_q, out_d;
  logic [3:0]       dir_rise;
  socd_mode_e       mode;

  // Simultaneous rises leave the axis with no winner until one side releases.
  function automatic axis_last_e axis_next(input axis_last_e last,
                                           input logic neg_rise, input logic pos_rise);
    if (neg_rise && pos_rise) return AX_NONE;
    if (neg_rise) return AX_NEG;
    if (pos_rise) return AX_POS;
    return last;
  endfunction

  // Returns {neg, pos} after applying the SOCD policy to one axis.
  function automatic logic [1:0] axis_resolve(input socd_mode_e m, input axis_last_e last,
                                              input logic neg, input logic pos);
    logic [1:0] r;
    r = {neg, pos};
    if (neg && pos) begin
      case (m)
        SOCD_NEUTRAL: r = 2'b00;
        SOCD_LAST:    r = {last == AX_NEG, last == AX_POS};
        default:      r = {neg, pos};
      endcase
    end
    return r;
  endfunction

  // Next-state: edge detection, axis memory, coin counter, pause latch, outputs.
  always_comb begin
    mode         = socd_mode_e'(socd_mode);
    dir_rise     = raw[3:0] & ~dir_prev_q;
    dir_prev_d   = raw[3:0];
    coin_prev_d  = raw[P_COIN];
    pause_prev_d = raw[P_PAUSE];
    h_last_d     = axis_next(h_last_q, dir_rise[JOY_LEFT], dir_rise[JOY_RIGHT]);
    v_last_d     = axis_next(v_last_q, dir_rise[JOY_DOWN], dir_rise[JOY_UP]);

    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 16'd1;
    end else if (raw[P_COIN] && !coin_prev_q) begin
      cnt_d = COIN_CYCLES;
    end

    out_d = raw;
    {out_d[JOY_LEFT], out_d[JOY_RIGHT]} = axis_resolve(mode, h_last_d, raw[JOY_LEFT], raw[JOY_RIGHT]);
    {out_d[JOY_DOWN], out_d[JOY_UP]}    = axis_resolve(mode, v_last_d, raw[JOY_DOWN], raw[JOY_UP]);
    out_d[P_COIN]  = (cnt_d != '0) || raw[P_COIN];
    out_d[P_PAUSE] = out_q[P_PAUSE] ^ (raw[P_PAUSE] && !pause_prev_q);
  end

  // State and output registers; reset abandons any coin pulse in flight.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      h_last_q     <= AX_NONE;
      v_last_q     <= AX_NONE;
      dir_prev_q   <= '0;
      coin_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      cnt_q        <= '0;
      out_q        <= '0;
    end else begin
      h_last_q     <= h_last_d;
      v_last_q     <= v_last_d;
      dir_prev_q   <= dir_prev_d;
      coin_prev_q  <= coin_prev_d;
      pause_prev_q <= pause_prev_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
    end
  end

  assign joy_out = out_q;

endmodule

// File: rtl/player_input.sv
// Merges PS/2 keyboard key state with per-player joystick inputs and
// conditions each player's controls through a player_channel.
module player_input
  import input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_BUTTONS = 3,
  parameter logic [15:0] COIN_CYCLES = 16'd4096
) (
  input  logic                                      clk_sys,
  input  logic                                      reset,
  input  logic [10:0]                               ps2_key,
  input  logic [NUM_PLAYERS*joy_w(NUM_BUTTONS)-1:0] joystick,
  input  logic [1:0]                                socd_mode,
  output logic [NUM_PLAYERS-1:0]                    up,
  output logic [NUM_PLAYERS-1:0]                    down,
  output logic [NUM_PLAYERS-1:0]                    left,
  output logic [NUM_PLAYERS-1:0]                    right,
  output logic [NUM_PLAYERS-1:0]                    start,
  output logic [NUM_PLAYERS-1:0]                    coin,
  output logic [NUM_PLAYERS-1:0]                    pause,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0]        buttons,
  output logic [1:0]                                service
);

  localparam int unsigned JOY_W      = joy_w(NUM_BUTTONS);
  localparam int unsigned KB_PLAYERS = (NUM_PLAYERS < KB_MAX_PLAYERS) ? NUM_PLAYERS : KB_MAX_PLAYERS;

  // Key state is kept directly in joystick bit layout so it ORs straight in.
  logic [KB_PLAYERS-1:0][JOY_W-1:0] key_q, key_d;
  logic [1:0] svc_key_q, svc_key_d;
  logic [1:0] service_q, service_d;
  logic       tog_q, tog_d;
  logic       armed_q, armed_d;
  logic       key_evt;
  logic [8:0] key_code;

  // Key event decode; the first clock after reset only captures the toggle bit.
  always_comb begin
    key_code  = ps2_key[8:0];
    key_evt   = armed_q && (ps2_key[10] != tog_q);
    key_d     = key_q;
    svc_key_d = svc_key_q;
    tog_d     = ps2_key[10];
    armed_d   = 1'b1;
    service_d = svc_key_q;
    if (key_evt) begin
      for (int unsigned p = 0; p < KB_PLAYERS; p++) begin
        for (int unsigned j = 0; j < JOY_W; j++) begin
          if (key_code == KEYMAP[p][joy_to_slot(j, NUM_BUTTONS)]) key_d[p][j] = ps2_key[9];
        end
      end
      if (key_code == SVC_KEY0) svc_key_d[0] = ps2_key[9];
      if (key_code == SVC_KEY1) svc_key_d[1] = ps2_key[9];
    end
  end

  // Keyboard state registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      key_q     <= '0;
      svc_key_q <= '0;
      service_q <= '0;
      tog_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      key_q     <= key_d;
      svc_key_q <= svc_key_d;
      service_q <= service_d;
      tog_q     <= tog_d;
      armed_q   <= armed_d;
    end
  end

  assign service = service_q;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [JOY_W-1:0] raw;
    logic [JOY_W-1:0] ch_out;

    if (p < KB_PLAYERS) begin : g_kb
      // Keyboard-mapped player: key state OR joystick.
      always_comb raw = key_q[p] | joystick[p*JOY_W +: JOY_W];
    end else begin : g_nokb
      // Players beyond the keyboard map see joystick only.
      always_comb raw = joystick[p*JOY_W +: JOY_W];
    end

    player_channel #(
      .NUM_BUTTONS (NUM_BUTTONS),
      .COIN_CYCLES (COIN_CYCLES)
    ) u_channel (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .socd_mode (socd_mode),
      .raw       (raw),
      .joy_out   (ch_out)
    );

    assign right[p] = ch_out[JOY_RIGHT];
    assign left[p]  = ch_out[JOY_LEFT];
    assign down[p]  = ch_out[JOY_DOWN];
    assign up[p]    = ch_out[JOY_UP];
    assign start[p] = ch_out[joy_start(NUM_BUTTONS)];
    assign coin[p]  = ch_out[joy_coin(NUM_BUTTONS)];
    assign pause[p] = ch_out[joy_pause(NUM_BUTTONS)];
    assign buttons[p*NUM_BUTTONS +: NUM_BUTTONS] = ch_out[JOY_BTN +: NUM_BUTTONS];
  end

endmodule

// File: tb/tb_player_input.sv
// Scoreboard bench for player_input: stimulus pushes expected output values
// tagged with the clock count at which they must hold; a negedge monitor
// pops and compares them.
module tb_player_input;

  localparam int unsigned NP = 2;
  localparam int unsigned NB = 3;
  localparam int unsigned JW = 10;

  localparam int S_UP = 0, S_DOWN = 1, S_LEFT = 2, S_RIGHT = 3, S_START = 4;
  localparam int S_COIN = 5, S_PAUSE = 6, S_BTN = 7, S_SVC = 8;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic [10:0]      ps2_key;
  logic [NP*JW-1:0] joystick;
  logic [1:0]       socd_mode;
  logic [NP-1:0]    up, down, left, right, start, coin, pause;
  logic [NP*NB-1:0] buttons;
  logic [1:0]       service;

  always #5 clk_sys = ~clk_sys;

  player_input #(
    .NUM_PLAYERS (NP),
    .NUM_BUTTONS (NB),
    .COIN_CYCLES (16'd8)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .joystick  (joystick),
    .socd_mode (socd_mode),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .start     (start),
    .coin      (coin),
    .pause     (pause),
    .buttons   (buttons),
    .service   (service)
  );

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [7:0]  exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int unsigned edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk_sys) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_UP:    return {6'b0, up};
      S_DOWN:  return {6'b0, down};
      S_LEFT:  return {6'b0, left};
      S_RIGHT: return {6'b0, right};
      S_START: return {6'b0, start};
      S_COIN:  return {6'b0, coin};
      S_PAUSE: return {6'b0, pause};
      S_BTN:   return {2'b0, buttons};
      S_SVC:   return {6'b0, service};
      default: return 8'hxx;
    endcase
  endfunction

  // Monitor: compare every expectation due at this clock count.
  always @(negedge clk_sys) begin
    int         i;
    logic [7:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= edge_cnt) begin
        got = obs(sb[i].sel);
        n_cmp++;
        if (sb[i].cyc != edge_cnt || got !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s at cycle %0d: got %0h, expected %0h", sb[i].name, sb[i].cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic exp_at(input int unsigned dly, input int sel, input logic [7:0] val, input string nm);
    chk_t c;
    c.cyc  = edge_cnt + dly;
    c.sel  = sel;
    c.exp  = val;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic ps2(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic joy_set(input int unsigned p, input int unsigned b, input logic v);
    joystick[p*JW + b] = v;
  endtask

  initial begin
    reset     = 1'b1;
    ps2_key   = '0;
    joystick  = '0;
    socd_mode = 2'd0;
    step(2);
    n_cmp++;
    if (coin !== 2'b00) begin
      n_bad++;
      $display("FAIL direct reset_coin: got %0h", coin);
    end
    for (int s = S_UP; s <= S_SVC; s++) exp_at(0, s, 8'h00, "reset_state");
    reset = 1'b0;
    step(2);

    // Extended E0 75 is player 0 up; plain 75 is unmapped.
    ps2(1'b1, 1'b1, 8'h75);
    exp_at(1, S_UP, 8'h00, "e075_latency1");
    exp_at(2, S_UP, 8'h01, "e075_press");
    step(3);
    n_cmp++;
    if (up !== 2'b01) begin
      n_bad++;
      $display("FAIL direct e075_up: got %0h", up);
    end
    ps2(1'b0, 1'b1, 8'h75);
    exp_at(2, S_UP, 8'h00, "e075_release");
    step(3);
    ps2(1'b1, 1'b0, 8'h75);
    exp_at(2, S_UP, 8'h00, "plain75_up");
    exp_at(2, S_DOWN, 8'h00, "plain75_down");
    exp_at(2, S_LEFT, 8'h00, "plain75_left");
    exp_at(2, S_RIGHT, 8'h00, "plain75_right");
    exp_at(2, S_BTN, 8'h00, "plain75_btn");
    step(3);
    ps2(1'b0, 1'b0, 8'h75);
    step(3);

    // Player 1 keyboard, service keys, buttons, start.
    ps2(1'b1, 1'b0, 8'h1D);
    exp_at(2, S_UP, 8'h02, "p1_w_press");
    step(3);
    ps2(1'b0, 1'b0, 8'h1D);
    exp_at(2, S_UP, 8'h00, "p1_w_release");
    step(3);
    ps2(1'b1, 1'b0, 8'h46);
    exp_at(2, S_SVC, 8'h01, "svc9_press");
    step(3);
    ps2(1'b1, 1'b0, 8'h45);
    exp_at(2, S_SVC, 8'h03, "svc0_press");
    step(3);
    ps2(1'b0, 1'b0, 8'h46);
    exp_at(2, S_SVC, 8'h02, "svc9_release");
    step(3);
    ps2(1'b0, 1'b0, 8'h45);
    exp_at(2, S_SVC, 8'h00, "svc0_release");
    step(3);
    ps2(1'b1, 1'b0, 8'h14);
    exp_at(2, S_BTN, 8'h01, "p0_btn0_key");
    step(3);
    joy_set(1, 6, 1'b1);
    exp_at(1, S_BTN, 8'h21, "p1_btn2_joy_or_key");
    step(3);
    ps2(1'b0, 1'b0, 8'h14);
    joy_set(1, 6, 1'b0);
    exp_at(1, S_BTN, 8'h01, "btn_mixed_latency");
    exp_at(2, S_BTN, 8'h00, "btn_all_released");
    step(3);
    ps2(1'b1, 1'b0, 8'h16);
    exp_at(2, S_START, 8'h01, "p0_start_key");
    step(3);
    ps2(1'b0, 1'b0, 8'h16);
    exp_at(2, S_START, 8'h00, "p0_start_release");
    step(3);

    // Last-wins on the horizontal axis.
    socd_mode = 2'd2;
    joy_set(0, 1, 1'b1);
    exp_at(1, S_LEFT, 8'h01, "lw_left_only");
    exp_at(1, S_RIGHT, 8'h00, "lw_right_idle");
    step(5);
    joy_set(0, 0, 1'b1);
    exp_at(1, S_RIGHT, 8'h01, "lw_right_wins");
    exp_at(1, S_LEFT, 8'h00, "lw_left_masked");
    exp_at(3, S_LEFT, 8'h00, "lw_left_still_masked");
    step(3);
    n_cmp++;
    if (right[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL direct lw_right: got %0h", right);
    end
    n_cmp++;
    if (left[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL direct lw_left: got %0h", left);
    end
    joy_set(0, 0, 1'b0);
    exp_at(1, S_LEFT, 8'h01, "lw_left_restored");
    exp_at(1, S_RIGHT, 8'h00, "lw_right_released");
    step(2);
    joy_set(0, 1, 1'b0);
    exp_at(1, S_LEFT, 8'h00, "lw_left_released");
    step(2);

    // Last-wins on the vertical axis.
    joy_set(0, 3, 1'b1);
    step(2);
    joy_set(0, 2, 1'b1);
    exp_at(1, S_DOWN, 8'h01, "lw_down_wins");
    exp_at(1, S_UP, 8'h00, "lw_up_masked");
    step(2);
    joy_set(0, 2, 1'b0);
    exp_at(1, S_UP, 8'h01, "lw_up_restored");
    step(2);
    joy_set(0, 3, 1'b0);
    step(2);

    // Last-wins with both directions rising together.
    joy_set(0, 0, 1'b1);
    joy_set(0, 1, 1'b1);
    exp_at(1, S_LEFT, 8'h00, "lw_simul_left");
    exp_at(1, S_RIGHT, 8'h00, "lw_simul_right");
    exp_at(3, S_LEFT, 8'h00, "lw_simul_left_hold");
    exp_at(3, S_RIGHT, 8'h00, "lw_simul_right_hold");
    step(3);
    joy_set(0, 1, 1'b0);
    exp_at(1, S_RIGHT, 8'h01, "lw_simul_right_after");
    exp_at(1, S_LEFT, 8'h00, "lw_simul_left_after");
    step(2);
    joy_set(0, 0, 1'b0);
    step(2);

    // Pass / neutral / reserved mode on player 1.
    socd_mode = 2'd0;
    joy_set(1, 0, 1'b1);
    joy_set(1, 1, 1'b1);
    exp_at(1, S_LEFT, 8'h02, "pass_left");
    exp_at(1, S_RIGHT, 8'h02, "pass_right");
    step(2);
    socd_mode = 2'd1;
    exp_at(1, S_LEFT, 8'h00, "neutral_left");
    exp_at(1, S_RIGHT, 8'h00, "neutral_right");
    step(2);
    n_cmp++;
    if (left !== 2'b00) begin
      n_bad++;
      $display("FAIL direct neutral_left: got %0h", left);
    end
    socd_mode = 2'd3;
    exp_at(1, S_LEFT, 8'h02, "mode3_left");
    exp_at(1, S_RIGHT, 8'h02, "mode3_right");
    step(2);
    joy_set(1, 0, 1'b0);
    joy_set(1, 1, 1'b0);
    socd_mode = 2'd0;
    step(2);

    // Coin stretch: 8 cycles from a 1-cycle pulse, retrigger ignored.
    exp_at(0, S_COIN, 8'h00, "coin_idle");
    joy_set(0, 8, 1'b1);
    for (int unsigned k = 1; k <= 8; k++) exp_at(k, S_COIN, 8'h01, "coin_stretch");
    exp_at(9, S_COIN, 8'h00, "coin_end");
    exp_at(10, S_COIN, 8'h00, "coin_no_extend");
    step(1);
    joy_set(0, 8, 1'b0);
    step(2);
    joy_set(0, 8, 1'b1);
    step(1);
    joy_set(0, 8, 1'b0);
    step(10);

    // Pause toggle latch.
    joy_set(0, 9, 1'b1);
    exp_at(1, S_PAUSE, 8'h01, "pause_on");
    step(1);
    joy_set(0, 9, 1'b0);
    exp_at(2, S_PAUSE, 8'h01, "pause_held_latched");
    step(3);
    joy_set(0, 9, 1'b1);
    exp_at(1, S_PAUSE, 8'h00, "pause_off");
    step(1);
    joy_set(0, 9, 1'b0);
    step(3);
    joy_set(0, 9, 1'b1);
    exp_at(1, S_PAUSE, 8'h01, "pause_on_again");
    exp_at(4, S_PAUSE, 8'h01, "pause_level_no_toggle");
    step(4);
    joy_set(0, 9, 1'b0);
    step(2);

    // Reset in the middle of a coin pulse, with a PS/2 toggle during reset.
    joy_set(0, 8, 1'b1);
    step(1);
    joy_set(0, 8, 1'b0);
    step(2);
    exp_at(0, S_COIN, 8'h01, "coin_before_reset");
    exp_at(0, S_PAUSE, 8'h01, "pause_before_reset");
    step(1);
    reset = 1'b1;
    ps2(1'b1, 1'b1, 8'h75);
    exp_at(0, S_COIN, 8'h00, "reset_coin");
    exp_at(0, S_PAUSE, 8'h00, "reset_pause");
    exp_at(0, S_UP, 8'h00, "reset_up");
    step(2);
    n_cmp++;
    if (pause !== 2'b00) begin
      n_bad++;
      $display("FAIL direct reset_pause: got %0h", pause);
    end
    reset = 1'b0;
    for (int unsigned k = 1; k <= 12; k++) exp_at(k, S_COIN, 8'h00, "coin_abandoned");
    exp_at(3, S_UP, 8'h00, "no_event_on_release");
    exp_at(5, S_UP, 8'h00, "no_event_later");
    step(12);
    ps2(1'b1, 1'b1, 8'h75);
    exp_at(2, S_UP, 8'h01, "key_after_reset");
    step(3);
    ps2(1'b0, 1'b1, 8'h75);
    exp_at(2, S_UP, 8'h00, "key_release_after_reset");
    step(3);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk_sys);
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s at cycle %0d: got no sample, expected %0h", sb[0].name, sb[0].cyc, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/player_input.md
PLAYER_INPUT -- requirements
Module: player_input

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player channels, legal range 1..4.
REQ-002 SHALL have parameter NUM_BUTTONS, default 3, action buttons per player, legal range 1..6.
REQ-003 SHALL have parameter COIN_CYCLES, default 16'd4096, minimum coin output pulse length in clk_sys cycles, legal range >=1.
REQ-004 SHALL have port clk_sys, input, 1 bit; the single clock.
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-006 SHALL have port ps2_key, input, 11 bits: [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scan code.
REQ-007 SHALL have port joystick, input, NUM_PLAYERS x JOY_W bits, where JOY_W = 7+NUM_BUTTONS; per player: [0] right, [1] left, [2] down, [3] up, [4+:NUM_BUTTONS] buttons, then start, coin, pause.
REQ-008 SHALL have port socd_mode, input, 2 bits: 0 pass, 1 neutral, 2 last-wins, 3 treated as 0.
REQ-009 SHALL have outputs up, down, left, right, start, coin, pause, each NUM_PLAYERS bits, one bit per player.
REQ-010 SHALL have output buttons, NUM_PLAYERS x NUM_BUTTONS bits.
REQ-011 SHALL have output service, 2 bits.

Function
REQ-012 SHALL detect a key event when ps2_key[10] differs from its registered copy; exactly one event per toggle.
REQ-013 SHALL match {ps2_key[8], ps2_key[7:0]} against the package keymap; extended and non-extended codes are distinct (E0 75 = up arrow; plain 75 = unmapped).
REQ-014 SHALL set a matched key-state bit to ps2_key[9] on the event cycle; unmatched events SHALL be ignored.
REQ-015 SHALL form each raw signal as key-state OR corresponding joystick bit.
REQ-016 SHALL register all outputs; latency: joystick change -> output 1 cycle; ps2 toggle -> output 2 cycles.
REQ-017 SHALL, per player, when socd_mode=1 and both left and right raw are high, drive left=right=0; likewise for up/down.
REQ-018 SHALL, per player, when socd_mode=2, remember the most recently asserted direction of each axis and output only that one while both are held; releasing it SHALL restore the still-held opposite next cycle.
REQ-019 SHALL, when both axis directions rise in the same cycle under mode 2, output neither until one releases.
REQ-020 SHALL stretch coin: on rising edge of raw coin load a per-player counter with COIN_CYCLES; coin output high while counter nonzero or raw coin high.
REQ-021 SHALL ignore a coin rising edge while that player's counter is nonzero (no retrigger extension).
REQ-022 SHALL toggle a per-player pause latch on each rising edge of raw pause; output pause = latch.
REQ-023 SHALL drive service[0]/service[1] from key-state of keys 9 (46) and 0 (45), registered.
REQ-024 SHALL tie off key-state for players >=2 (keyboard maps only players 0 and 1).

Reset
REQ-025 SHALL, while reset is high, clear every key-state bit, the toggle copy, SOCD memory, coin counters, pause latches and all outputs to 0.
REQ-026 SHALL, on reset release, capture ps2_key[10] into the toggle copy on the first clock so no spurious event is seen.
REQ-027 SHALL abandon a coin pulse in progress when reset asserts mid-pulse.

Structure
REQ-028 SHALL take keymap table, JOY_W function, SOCD mode encodings and joystick bit-offset constants from shared package input_pkg.
REQ-029 SHALL instantiate one per-player sub-module player_channel (SOCD, coin stretch, pause latch) in a generate loop.

Verification
REQ-030 SHALL check: toggle ps2_key with pressed=1, ext=1, code 75 -> up[0]=1 two cycles later; same code with ext=0 -> no change.
REQ-031 SHALL check: socd_mode=2, hold left, then right 5 cycles later -> right=1, left=0; release right -> left=1 next cycle.
REQ-032 SHALL check: socd_mode=1, joystick[1] left and right high -> left[1]=right[1]=0.
REQ-033 SHALL check: COIN_CYCLES=8, 1-cycle coin pulse -> coin[0] high exactly 8 cycles; second pulse at cycle 4 -> no extension.
REQ-034 SHALL check: two pause pulses -> pause 1 then 0; reset mid-coin-pulse -> all outputs 0 next cycle and no event on release.
